sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO, the successor to the depth-1 FIFO used in the pipeline handshakes. It adds configurable depth, full/almost-full/almost-empty flags, an occupancy count, overflow/underflow error pulses, and a selectable output mode: show-ahead or registered read. Typical use is buffering between the IF/ID stages and the AXI read/write channels.

---
 rtl/sync_fifo_param.sv | 120 ++++++++++++
 tb/tb_sync_fifo_param.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
// Parametrised single-clock FIFO. It has full, almost-full and almost-empty
// flags, an occupancy count, and one-cycle overflow/underflow pulses. The
// output can run in one of two modes:
//   - show-ahead: the head entry is always presented on fifo_out;
//   - registered: fifo_out is loaded on an accepted read.
//
// Ports
//   clk               rising-edge clock
//   rst               synchronous active-high reset
//   write, fifo_in    push request and push data
//   read              pop request
//   fifo_out          read data (the head entry, or the last popped entry)
//   fifo_empty        count == 0
//   fifo_full         count == FIFO_DEPTH
//   fifo_almost_full  count >= AFULL_THRESH
//   fifo_almost_empty count <= AEMPTY_THRESH
//   fifo_count        current occupancy
//   overflow          one-cycle pulse when a write is dropped
//   underflow         one-cycle pulse when a read is dropped
module sync_fifo_param #(
  parameter int FIFO_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 1,
  parameter int AEMPTY_THRESH = 1,
  parameter bit SHOW_AHEAD    = 1'b1,
  localparam int CW           = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write,
  input  logic [FIFO_WIDTH-1:0] fifo_in,
  input  logic                  read,
  output logic [FIFO_WIDTH-1:0] fifo_out,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  fifo_almost_full,
  output logic                  fifo_almost_empty,
  output logic [CW-1:0]         fifo_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, full_q, afull_q, aempty_q;
  logic          overflow_q, underflow_q;
  logic          wr_acc, rd_acc;

  // A write into a full FIFO is still accepted when the head leaves on the
  // same edge: the slot being vacated is the one wr_ptr points at.
  always_comb begin
    rd_acc   = read & ~empty_q;
    wr_acc   = write & (~full_q | rd_acc);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
  end

  // The flags are derived from count_d, so they line up with fifo_count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      afull_q     <= (AFULL_THRESH == 0);
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= (count_d == '0);
      full_q      <= (count_d == FULL_CNT);
      afull_q     <= (int'(count_d) >= AFULL_THRESH);
      aempty_q    <= (int'(count_d) <= AEMPTY_THRESH);
      overflow_q  <= write & ~wr_acc;
      underflow_q <= read & ~rd_acc;
    end
  end

  // Storage is not reset. A write in the same cycle as reset is suppressed.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= fifo_in;
  end

  if (SHOW_AHEAD) begin : g_show_ahead
    assign fifo_out = mem_q[rd_ptr_q];
  end else begin : g_reg_out
    logic [FIFO_WIDTH-1:0] dout_q;
    // Both the read and a same-edge write into the slot being vacated happen
    // at the clock edge, so the read takes the old head value.
    always_ff @(posedge clk) begin
      if (rst)         dout_q <= '0;
      else if (rd_acc) dout_q <= mem_q[rd_ptr_q];
    end
    assign fifo_out = dout_q;
  end

  assign fifo_empty        = empty_q;
  assign fifo_full         = full_q;
  assign fifo_almost_full  = afull_q;
  assign fifo_almost_empty = aempty_q;
  assign fifo_count        = count_q;
  assign overflow          = overflow_q;
  assign underflow         = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Testbench for sync_fifo_param with two instances:
//   A: depth 4, show-ahead
//   B: depth 3, registered output
// Expected read data is pushed into a queue when a read is issued. The monitor
// processes pop that queue and compare it against what the DUT presents.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total_cnt = 0;
  int pass_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- instance A: DEPTH=4, SHOW_AHEAD=1 ----------------
  logic       rst_a = 1'b0, wr_a = 1'b0, rd_a = 1'b0;
  logic [7:0] din_a = '0, dout_a;
  logic       empty_a, full_a, af_a, ae_a, ov_a, un_a;
  logic [2:0] cnt_a;

  sync_fifo_param #(.FIFO_WIDTH(8), .FIFO_DEPTH(4), .SHOW_AHEAD(1'b1)) u_a (
    .clk(clk), .rst(rst_a), .write(wr_a), .fifo_in(din_a), .read(rd_a),
    .fifo_out(dout_a), .fifo_empty(empty_a), .fifo_full(full_a),
    .fifo_almost_full(af_a), .fifo_almost_empty(ae_a), .fifo_count(cnt_a),
    .overflow(ov_a), .underflow(un_a));

  // ---------------- instance B: DEPTH=3, SHOW_AHEAD=0 ----------------
  logic       rst_b = 1'b0, wr_b = 1'b0, rd_b = 1'b0;
  logic [7:0] din_b = '0, dout_b;
  logic       empty_b, full_b, af_b, ae_b, ov_b, un_b;
  logic [1:0] cnt_b;

  sync_fifo_param #(.FIFO_WIDTH(8), .FIFO_DEPTH(3), .SHOW_AHEAD(1'b0)) u_b (
    .clk(clk), .rst(rst_b), .write(wr_b), .fifo_in(din_b), .read(rd_b),
    .fifo_out(dout_b), .fifo_empty(empty_b), .fifo_full(full_b),
    .fifo_almost_full(af_b), .fifo_almost_empty(ae_b), .fifo_count(cnt_b),
    .overflow(ov_b), .underflow(un_b));

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  // Monitor A: in show-ahead mode the popped word is on fifo_out during the
  // cycle in which the read is presented to a non-empty FIFO.
  always @(negedge clk) begin
    if (rd_a && !empty_a && !rst_a) begin
      if (exp_a.size() == 0) chk("a_unexpected_pop", 32'(dout_a), 32'hDEAD);
      else chk("a_read_data", 32'(dout_a), 32'(exp_a.pop_front()));
    end
  end

  // Monitor B: the registered output changes one cycle after an accepted read
  // and holds its value in every other cycle.
  logic       b_live = 1'b0;
  logic       pend_b = 1'b0;
  logic [7:0] last_b = 8'h00;
  always @(negedge clk) begin
    if (b_live) begin
      if (pend_b) begin
        if (exp_b.size() == 0) chk("b_unexpected_pop", 32'(dout_b), 32'hDEAD);
        else begin
          last_b = exp_b.pop_front();
          chk("b_read_data", 32'(dout_b), 32'(last_b));
        end
      end else begin
        chk("b_hold", 32'(dout_b), 32'(last_b));
      end
    end
    pend_b = rd_b && !empty_b && !rst_b;
  end

  task automatic cyc_a(input logic w, input logic [7:0] d, input logic r);
    wr_a = w; din_a = d; rd_a = r;
    @(posedge clk); #1;
    wr_a = 1'b0; rd_a = 1'b0;
  endtask

  task automatic pop_a(input logic [7:0] e);
    exp_a.push_back(e);
    cyc_a(1'b0, 8'h00, 1'b1);
  endtask

  // Flag vector is {count, empty, full, almost_full, almost_empty, overflow, underflow}.
  task automatic flags_a(input string name, input logic [8:0] e);
    chk(name, 32'({cnt_a, empty_a, full_a, af_a, ae_a, ov_a, un_a}), 32'(e));
  endtask

  task automatic cyc_b(input logic w, input logic [7:0] d, input logic r);
    wr_b = w; din_b = d; rd_b = r;
    if (r) exp_b.push_back(8'h00);
    @(posedge clk); #1;
    wr_b = 1'b0; rd_b = 1'b0;
  endtask

  // Directed interleaved sequence for B: write flag, data, read flag, the
  // expected count after the edge, and the word the read should return.
  logic       tw [11] = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 0, 0};
  logic [7:0] td [11] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'h00, 8'h00, 8'hA6, 8'h00, 8'h00};
  logic       tr [11] = '{0, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1};
  logic [1:0] tc [11] = '{1, 2, 2, 2, 3, 3, 2, 1, 2, 1, 0};
  logic [7:0] te [11] = '{8'h00, 8'h00, 8'hA0, 8'hA1, 8'h00, 8'hA2, 8'hA3, 8'hA4, 8'h00, 8'hA5, 8'hA6};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- A: reset ----------------
    rst_a = 1'b1; rst_b = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;
    flags_a("a_reset_flags", {3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});

    // ---------------- A: fill 0x11..0x44 ----------------
    cyc_a(1'b1, 8'h11, 1'b0);
    flags_a("a_fill1", {3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    chk("a_show_ahead_first", 32'(dout_a), 32'h11);
    cyc_a(1'b1, 8'h22, 1'b0);
    flags_a("a_fill2", {3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    cyc_a(1'b1, 8'h33, 1'b0);
    flags_a("a_fill3", {3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    cyc_a(1'b1, 8'h44, 1'b0);
    flags_a("a_fill4", {3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("a_head_after_fill", 32'(dout_a), 32'h11);

    // ---------------- A: overflow ----------------
    cyc_a(1'b1, 8'h55, 1'b0);
    flags_a("a_overflow", {3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    cyc_a(1'b0, 8'h00, 1'b0);
    flags_a("a_overflow_clear", {3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    pop_a(8'h11);
    flags_a("a_drain1", {3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    pop_a(8'h22);
    pop_a(8'h33);
    flags_a("a_drain3", {3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    pop_a(8'h44);
    flags_a("a_drained", {3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});

    // ---------------- A: simultaneous read/write while full ----------------
    cyc_a(1'b1, 8'h11, 1'b0);
    cyc_a(1'b1, 8'h22, 1'b0);
    cyc_a(1'b1, 8'h33, 1'b0);
    cyc_a(1'b1, 8'h44, 1'b0);
    exp_a.push_back(8'h11);
    cyc_a(1'b1, 8'h66, 1'b1);
    flags_a("a_full_rw", {3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("a_full_rw_head", 32'(dout_a), 32'h22);
    pop_a(8'h22);
    pop_a(8'h33);
    pop_a(8'h44);
    pop_a(8'h66);
    flags_a("a_drained2", {3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});

    // ---------------- A: underflow ----------------
    cyc_a(1'b0, 8'h00, 1'b1);
    flags_a("a_underflow", {3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    cyc_a(1'b0, 8'h00, 1'b0);
    flags_a("a_underflow_clear", {3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    cyc_a(1'b1, 8'h77, 1'b1);
    flags_a("a_empty_rw", {3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    chk("a_empty_rw_data", 32'(dout_a), 32'h77);
    pop_a(8'h77);
    flags_a("a_empty_rw_drain", {3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});

    // ---------------- A: reset mid-stream ----------------
    cyc_a(1'b1, 8'h81, 1'b0);
    cyc_a(1'b1, 8'h82, 1'b0);
    cyc_a(1'b1, 8'h83, 1'b0);
    flags_a("a_pre_reset", {3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    rst_a = 1'b1; wr_a = 1'b1; din_a = 8'hEE;
    @(posedge clk); #1;
    rst_a = 1'b0; wr_a = 1'b0;
    flags_a("a_mid_reset", {3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    cyc_a(1'b1, 8'h99, 1'b0);
    flags_a("a_post_reset_wr", {3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    chk("a_post_reset_head", 32'(dout_a), 32'h99);
    pop_a(8'h99);
    flags_a("a_post_reset_rd", {3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});

    // ---------------- B: registered mode, depth 3 ----------------
    chk("b_reset_out", 32'(dout_b), 32'h00);
    chk("b_reset_flags", 32'({cnt_b, empty_b, full_b, af_b, ae_b, ov_b, un_b}),
        32'({2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}));
    b_live = 1'b1;
    for (int i = 0; i < 11; i++) begin
      wr_b = tw[i]; din_b = td[i]; rd_b = tr[i];
      if (tr[i]) exp_b.push_back(te[i]);
      @(posedge clk); #1;
      wr_b = 1'b0; rd_b = 1'b0;
      chk($sformatf("b_count_%0d", i), 32'(cnt_b), 32'(tc[i]));
      if (tr[i]) chk($sformatf("b_out_after_read_%0d", i), 32'(dout_b), 32'(te[i]));
      if (tc[i] == 2'd3) chk($sformatf("b_full_%0d", i), 32'({full_b, af_b}), 32'b11);
    end
    // A read on the empty FIFO must pulse underflow and leave fifo_out alone.
    wr_b = 1'b0; rd_b = 1'b1;
    @(posedge clk); #1;
    rd_b = 1'b0;
    chk("b_underflow", 32'({cnt_b, empty_b, un_b}), 32'({2'd0, 1'b1, 1'b1}));
    chk("b_hold_on_empty", 32'(dout_b), 32'hA6);
    repeat (3) @(posedge clk);
    #1;

    chk("a_scoreboard_empty", 32'(exp_a.size()), 32'd0);
    chk("b_scoreboard_empty", 32'(exp_b.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
